// File: rtl/expander_pkg.sv
// Shared types for the MCU port expander.
// op_e    : command opcode carried in the top two bits of the MCU nibble bus.
// state_e : controller states.
package expander_pkg;

    localparam int BUS_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        READ   = 2'b00,
        WRITE  = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_TURN,
        RD_DRIVE,
        WR_WAIT,
        IGNORE
    } state_e;

endpackage

// File: rtl/expander_sampler.sv
// Brings the asynchronous PROG strobe into the clk domain and delays the bus
// samples by the same number of stages, so a bus sample always belongs to the
// prog_n level it is reported with.
// Ports:
//   clk, rst   system clock, async active-high reset
//   prog_n     raw MCU PROG strobe
//   bus_in     raw P2 bus (FPGA side of the translator)
//   bus_s      bus sample aligned with the synchronised prog_n
//   bus_last   bus_s one cycle earlier (the last low-cycle sample at a rise)
//   fall, rise one-cycle pulses on synchronised prog_n edges
module expander_sampler #(
    parameter int BUS_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_n,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_s,
    output logic [BUS_W-1:0] bus_last,
    output logic             fall,
    output logic             rise
);

    logic [SYNC_STAGES-1:0]            prog_sync_q, prog_sync_d;
    logic [SYNC_STAGES-1:0][BUS_W-1:0] bus_dly_q, bus_dly_d;
    logic                              prog_prev_q, prog_prev_d;
    logic [BUS_W-1:0]                  bus_last_q, bus_last_d;

    always_comb begin
        prog_sync_d = {prog_sync_q[SYNC_STAGES-2:0], prog_n};
        bus_dly_d   = {bus_dly_q[SYNC_STAGES-2:0], bus_in};
        prog_prev_d = prog_sync_q[SYNC_STAGES-1];
        bus_last_d  = bus_dly_q[SYNC_STAGES-1];
    end

    // The chain resets to "low" so that a strobe already low when reset is
    // released never produces a fall; a command needs a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_sync_q <= '0;
            bus_dly_q   <= '0;
            prog_prev_q <= 1'b0;
            bus_last_q  <= '0;
        end else begin
            prog_sync_q <= prog_sync_d;
            bus_dly_q   <= bus_dly_d;
            prog_prev_q <= prog_prev_d;
            bus_last_q  <= bus_last_d;
        end
    end

    assign bus_s    = bus_dly_q[SYNC_STAGES-1];
    assign bus_last = bus_last_q;
    assign fall     = prog_prev_q & ~prog_sync_q[SYNC_STAGES-1];
    assign rise     = ~prog_prev_q & prog_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_port_expander.sv
// MCU I/O-expander slave: decodes PROG-strobed {op,addr} commands from the
// nibble bus, steers the level translator and holds per-port registers.
// Ports:
//   clk, rst            system clock, async active-high reset
//   prog_n, bus_in      MCU strobe and sampled P2 bus
//   bus_out, bus_oe     read data and its tristate enable
//   buf_dir, buf_oe     translator direction (1 = FPGA->MCU) and enable
//   port_in/port_out    per-port external inputs / port registers
//   port_is_out         per-port direction flag (1 after WRITE/OR/AND)
//   wr_stb, rd_stb      per-port completion pulses
//   err_addr            sticky, out-of-range address seen
//   err_timeout         sticky, prog_n held low too long
//
// state    | meaning
// IDLE     | waiting for a prog_n fall
// RD_TURN  | READ captured, waiting for the MCU to release the bus
// RD_DRIVE | translator turned, driving port_in[addr] until rise
// WR_WAIT  | WRITE/OR/AND captured, data taken at rise
// IGNORE   | bad address or timeout, wait for rise without driving
module mcu_port_expander
    import expander_pkg::*;
#(
    parameter int               BUS_W       = BUS_W_DEFAULT,
    parameter int               NUM_PORTS   = 4,
    parameter int               SYNC_STAGES = 2,
    parameter int               TURN_CYC    = 3,
    parameter int               TIMEOUT_CYC = 1024,
    parameter logic [BUS_W-1:0] RST_VAL     = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_n,
    input  logic [BUS_W-1:0]           bus_in,
    output logic [BUS_W-1:0]           bus_out,
    output logic                       bus_oe,
    output logic                       buf_dir,
    output logic                       buf_oe,
    input  logic [NUM_PORTS*BUS_W-1:0] port_in,
    output logic [NUM_PORTS*BUS_W-1:0] port_out,
    output logic [NUM_PORTS-1:0]       port_is_out,
    output logic [NUM_PORTS-1:0]       wr_stb,
    output logic [NUM_PORTS-1:0]       rd_stb,
    output logic                       err_addr,
    output logic                       err_timeout
);

    localparam int AW = BUS_W - 2;
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam int OW = $clog2(TIMEOUT_CYC + 1);

    logic [BUS_W-1:0] bus_s, bus_last, rd_data;
    logic             fall, rise;
    op_e              cmd_op;
    logic [AW-1:0]    cmd_addr;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [OW-1:0]    tmo_q, tmo_d;
    logic [BUS_W-1:0] bus_out_q, bus_out_d;
    logic             bus_oe_q, bus_oe_d;
    logic             buf_dir_q, buf_dir_d;
    logic             err_addr_q, err_addr_d;
    logic             err_timeout_q, err_timeout_d;
    logic             wr_req, rd_done, rd_clr;

    expander_sampler #(
        .BUS_W       (BUS_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .prog_n   (prog_n),
        .bus_in   (bus_in),
        .bus_s    (bus_s),
        .bus_last (bus_last),
        .fall     (fall),
        .rise     (rise)
    );

    assign cmd_op   = op_e'(bus_s[BUS_W-1 -: 2]);
    assign cmd_addr = bus_s[AW-1:0];
    assign rd_data  = port_in[int'(addr_q)*BUS_W +: BUS_W];

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        turn_d        = turn_q;
        tmo_d         = tmo_q;
        bus_out_d     = '0;
        bus_oe_d      = 1'b0;
        buf_dir_d     = 1'b0;
        err_addr_d    = err_addr_q;
        err_timeout_d = err_timeout_q;
        wr_req        = 1'b0;
        rd_done       = 1'b0;
        rd_clr        = 1'b0;

        if (state_q != IDLE && tmo_q != '0)
            tmo_d = tmo_q - OW'(1);

        case (state_q)
            IDLE: begin
                tmo_d = OW'(TIMEOUT_CYC - 1);
                if (fall) begin
                    if (int'(cmd_addr) >= NUM_PORTS) begin
                        err_addr_d = 1'b1;
                        state_d    = IGNORE;
                    end else begin
                        op_d   = cmd_op;
                        addr_d = cmd_addr;
                        if (cmd_op == READ) begin
                            turn_d  = TW'(TURN_CYC - 1);
                            state_d = RD_TURN;
                        end else begin
                            state_d = WR_WAIT;
                        end
                    end
                end
            end
            RD_TURN: begin
                if (rise) begin
                    rd_done = 1'b1;
                    state_d = IDLE;
                end else if (turn_q == '0) begin
                    // Turn the translator first; bus_oe follows one cycle later.
                    buf_dir_d = 1'b1;
                    bus_out_d = rd_data;
                    rd_clr    = 1'b1;
                    state_d   = RD_DRIVE;
                end else begin
                    turn_d = turn_q - TW'(1);
                end
            end
            RD_DRIVE: begin
                buf_dir_d = 1'b1;
                if (rise) begin
                    // bus_oe drops now, buf_dir a cycle later, so the bus is
                    // never driven against a translator pointing inward.
                    rd_done = 1'b1;
                    state_d = IDLE;
                end else begin
                    bus_oe_d  = 1'b1;
                    bus_out_d = rd_data;
                end
            end
            WR_WAIT: begin
                if (rise) begin
                    wr_req  = 1'b1;
                    state_d = IDLE;
                end
            end
            IGNORE: begin
                if (rise)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !rise && tmo_q == '0) begin
            bus_oe_d      = 1'b0;
            buf_dir_d     = 1'b0;
            bus_out_d     = '0;
            rd_clr        = 1'b0;
            err_timeout_d = 1'b1;
            state_d       = IGNORE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            op_q          <= READ;
            addr_q        <= '0;
            turn_q        <= '0;
            tmo_q         <= OW'(TIMEOUT_CYC - 1);
            bus_out_q     <= '0;
            bus_oe_q      <= 1'b0;
            buf_dir_q     <= 1'b0;
            err_addr_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            turn_q        <= turn_d;
            tmo_q         <= tmo_d;
            bus_out_q     <= bus_out_d;
            bus_oe_q      <= bus_oe_d;
            buf_dir_q     <= buf_dir_d;
            err_addr_q    <= err_addr_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [AW-1:0] P_ADDR = AW'(p);
        logic             hit;
        logic [BUS_W-1:0] port_q, port_d;
        logic             is_out_q, is_out_d;
        logic             wr_stb_q, wr_stb_d;
        logic             rd_stb_q, rd_stb_d;

        assign hit = (addr_q == P_ADDR);

        always_comb begin
            port_d   = port_q;
            is_out_d = is_out_q;
            wr_stb_d = wr_req & hit;
            rd_stb_d = rd_done & hit;
            if (wr_req && hit) begin
                is_out_d = 1'b1;
                case (op_q)
                    WRITE:   port_d = bus_last;
                    OP_OR:   port_d = port_q | bus_last;
                    OP_AND:  port_d = port_q & bus_last;
                    default: port_d = port_q;
                endcase
            end else if (rd_clr && hit) begin
                is_out_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                port_q   <= RST_VAL;
                is_out_q <= 1'b0;
                wr_stb_q <= 1'b0;
                rd_stb_q <= 1'b0;
            end else begin
                port_q   <= port_d;
                is_out_q <= is_out_d;
                wr_stb_q <= wr_stb_d;
                rd_stb_q <= rd_stb_d;
            end
        end

        assign port_out[p*BUS_W +: BUS_W] = port_q;
        assign port_is_out[p]             = is_out_q;
        assign wr_stb[p]                  = wr_stb_q;
        assign rd_stb[p]                  = rd_stb_q;
    end

    assign bus_out     = bus_out_q;
    assign bus_oe      = bus_oe_q;
    assign buf_dir     = buf_dir_q;
    assign buf_oe      = 1'b1;
    assign err_addr    = err_addr_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mcu_port_expander.sv
module tb_mcu_port_expander;
    import expander_pkg::*;

    localparam int K_WR = 0;
    localparam int K_RD = 1;

    typedef struct {
        int         kind;
        int         port;
        logic [3:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_n;
    logic [3:0]  bus_in;

    logic [3:0]  bus_out;
    logic        bus_oe, buf_dir, buf_oe;
    logic [15:0] port_in;
    logic [15:0] port_out;
    logic [3:0]  port_is_out, wr_stb, rd_stb;
    logic        err_addr, err_timeout;

    logic [3:0]  bus_out3;
    logic        bus_oe3, buf_dir3, buf_oe3;
    logic [11:0] port_in3;
    logic [11:0] port_out3;
    logic [2:0]  port_is_out3, wr_stb3, rd_stb3;
    logic        err_addr3, err_timeout3;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [3:0]  mdl[4];
    int          wr_cnt[4];
    int          rd_cnt[4];
    int          oe3_cnt = 0;
    int          stb3_cnt = 0;
    logic        oe_prev = 1'b0;
    logic        dir_prev = 1'b0;

    always #10 clk = ~clk;

    mcu_port_expander dut (
        .clk(clk), .rst(rst), .prog_n(prog_n), .bus_in(bus_in),
        .bus_out(bus_out), .bus_oe(bus_oe), .buf_dir(buf_dir), .buf_oe(buf_oe),
        .port_in(port_in), .port_out(port_out), .port_is_out(port_is_out),
        .wr_stb(wr_stb), .rd_stb(rd_stb),
        .err_addr(err_addr), .err_timeout(err_timeout)
    );

    mcu_port_expander #(.NUM_PORTS(3)) dut3 (
        .clk(clk), .rst(rst), .prog_n(prog_n), .bus_in(bus_in),
        .bus_out(bus_out3), .bus_oe(bus_oe3), .buf_dir(buf_dir3), .buf_oe(buf_oe3),
        .port_in(port_in3), .port_out(port_out3), .port_is_out(port_is_out3),
        .wr_stb(wr_stb3), .rd_stb(rd_stb3),
        .err_addr(err_addr3), .err_timeout(err_timeout3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: writes are checked at wr_stb, reads when bus_oe rises.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int p = 0; p < 4; p++) begin
                if (wr_stb[p]) wr_cnt[p]++;
                if (rd_stb[p]) rd_cnt[p]++;
            end
            if (|wr_stb) begin
                if (sb.size() == 0 || sb[0].kind != K_WR) begin
                    chk("wr_unexpected", 32'(wr_stb), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wr_stb_port", 32'(wr_stb), 32'd1 << e.port);
                    chk("wr_port_out", 32'(port_out[e.port*4 +: 4]), 32'(e.data));
                end
            end
            if (bus_oe && !oe_prev) begin
                chk("dir_leads_oe", 32'(dir_prev), 32'd1);
                if (sb.size() == 0 || sb[0].kind != K_RD) begin
                    chk("oe_unexpected", 32'(bus_oe), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_bus_data", 32'(bus_out), 32'(e.data));
                end
            end
            if (bus_oe) chk("oe_without_dir", 32'(buf_dir), 32'd1);
            if (bus_oe3) oe3_cnt++;
            if (|wr_stb3 || |rd_stb3) stb3_cnt++;
        end
        oe_prev  = bus_oe;
        dir_prev = buf_dir;
    end

    task automatic cmd_start(input logic [3:0] cmd);
        bus_in = cmd;
        #50 prog_n = 1'b0;
        #60 bus_in = 4'h0;
    endtask

    task automatic cmd_end();
        prog_n = 1'b1;
        #20 bus_in = 4'h0;
        #280;
    endtask

    task automatic mcu_write(input logic [1:0] op, input logic [1:0] addr, input logic [3:0] data);
        logic [3:0] nv;
        case (op)
            2'b01:   nv = data;
            2'b10:   nv = mdl[addr] | data;
            2'b11:   nv = mdl[addr] & data;
            default: nv = mdl[addr];
        endcase
        mdl[addr] = nv;
        sb.push_back('{K_WR, int'(addr), nv});
        cmd_start({op, addr});
        bus_in = data;
        #200;
        cmd_end();
    endtask

    initial begin
        int rd_before;
        int wr_before;
        rst      = 1'b1;
        prog_n   = 1'b1;
        bus_in   = 4'h0;
        port_in  = {4'h7, 4'hA, 4'h5, 4'h3};
        port_in3 = {4'hC, 4'h6, 4'h9};
        for (int p = 0; p < 4; p++) begin
            mdl[p]    = 4'hF;
            wr_cnt[p] = 0;
            rd_cnt[p] = 0;
        end
        #25 rst = 1'b0;
        #1000;

        // reset / idle state
        chk("rst_port_out", 32'(port_out), 32'hFFFF);
        chk("rst_port_out3", 32'(port_out3), 32'hFFF);
        chk("rst_bus_oe", 32'(bus_oe), 32'd0);
        chk("rst_buf_dir", 32'(buf_dir), 32'd0);
        chk("rst_buf_oe", 32'(buf_oe), 32'd1);
        chk("rst_bus_out", 32'(bus_out), 32'd0);
        chk("rst_is_out", 32'(port_is_out), 32'd0);
        chk("rst_errs", 32'({err_addr, err_timeout}), 32'd0);
        chk("rst_no_strobes", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3]
                                  + rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3]), 32'd0);

        // WRITE port1
        mcu_write(2'b01, 2'd1, 4'h4);
        chk("wr1_value", 32'(port_out[7:4]), 32'h4);
        chk("wr1_stb_count", 32'(wr_cnt[1]), 32'd1);
        chk("wr1_is_out", 32'(port_is_out[1]), 32'd1);

        // READ port2 after it was made an output
        mcu_write(2'b01, 2'd2, 4'h2);
        chk("wr2_is_out", 32'(port_is_out[2]), 32'd1);
        rd_before = rd_cnt[2];
        sb.push_back('{K_RD, 2, 4'hA});
        cmd_start(4'h2);
        #550;
        chk("rd2_bus_oe", 32'(bus_oe), 32'd1);
        chk("rd2_bus_out", 32'(bus_out), 32'hA);
        chk("rd2_buf_dir", 32'(buf_dir), 32'd1);
        chk("rd2_is_out_clr", 32'(port_is_out[2]), 32'd0);
        cmd_end();
        chk("rd2_released", 32'(bus_oe), 32'd0);
        chk("rd2_dir_back", 32'(buf_dir), 32'd0);
        chk("rd2_stb_count", 32'(rd_cnt[2] - rd_before), 32'd1);

        // READ addr 3: valid for the 4-port instance, out of range for 3 ports
        chk("a3_err_before", 32'(err_addr3), 32'd0);
        oe3_cnt  = 0;
        stb3_cnt = 0;
        sb.push_back('{K_RD, 3, 4'h7});
        cmd_start(4'h3);
        #550;
        chk("rd3_bus_out", 32'(bus_out), 32'h7);
        cmd_end();
        chk("a3_oe_never", 32'(oe3_cnt), 32'd0);
        chk("a3_err_addr", 32'(err_addr3), 32'd1);
        chk("a3_no_strobes", 32'(stb3_cnt), 32'd0);
        chk("a3_dut4_no_err", 32'(err_addr), 32'd0);

        stb3_cnt = 0;
        mcu_write(2'b01, 2'd0, 4'h5);
        chk("a3_next_write", 32'(port_out3[3:0]), 32'h5);
        chk("a3_next_stb", 32'(stb3_cnt), 32'd1);
        chk("a3_next_is_out", 32'(port_is_out3[0]), 32'd1);
        chk("wr0_value", 32'(port_out[3:0]), 32'h5);

        // AND / OR
        mcu_write(2'b11, 2'd3, 4'b1101);
        chk("and3_value", 32'(port_out[15:12]), 32'hD);
        mcu_write(2'b10, 2'd3, 4'b0010);
        chk("or3_value", 32'(port_out[15:12]), 32'hF);
        chk("or3_is_out", 32'(port_is_out[3]), 32'd1);
        mcu_write(2'b11, 2'd1, 4'h6);
        chk("and1_value", 32'(port_out[7:4]), 32'h4);
        mcu_write(2'b10, 2'd0, 4'hA);
        chk("or0_value", 32'(port_out[3:0]), 32'hF);

        // timeout: prog_n held low for 2000 cycles during a READ
        rd_before = rd_cnt[0];
        sb.push_back('{K_RD, 0, 4'h3});
        cmd_start(4'h0);
        #19940;
        chk("tmo_still_driving", 32'(bus_oe), 32'd1);
        chk("tmo_not_yet", 32'(err_timeout), 32'd0);
        #1200;
        chk("tmo_err", 32'(err_timeout), 32'd1);
        chk("tmo_oe_off", 32'(bus_oe), 32'd0);
        chk("tmo_dir_off", 32'(buf_dir), 32'd0);
        #18800;
        cmd_end();
        chk("tmo_no_rd_stb", 32'(rd_cnt[0] - rd_before), 32'd0);
        chk("tmo_sticky", 32'(err_timeout), 32'd1);

        // reset in the middle of a WRITE
        wr_before = wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3];
        cmd_start(4'h5);
        bus_in = 4'h9;
        #100 rst = 1'b1;
        #40 rst = 1'b0;
        #100;
        cmd_end();
        for (int p = 0; p < 4; p++) mdl[p] = 4'hF;
        chk("rstw_no_wr_stb", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3] - wr_before), 32'd0);
        chk("rstw_port_out", 32'(port_out), 32'hFFFF);
        chk("rstw_errs", 32'({err_addr3, err_timeout}), 32'd0);

        mcu_write(2'b01, 2'd1, 4'h7);
        chk("post_rst_write", 32'(port_out[7:4]), 32'h7);

        #200;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
